// File: rtl/fpa_pkg.sv
// Shared definitions for the sequential floating-point adder: FSM state
// encoding and the bit positions inside the ans_except flag vector.
package fpa_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } fpa_state_e;

  // ans_except = {zero, overflow, underflow, invalid}
  localparam int EXC_W    = 4;
  localparam int EXC_ZERO = 3;
  localparam int EXC_OVF  = 2;
  localparam int EXC_UNF  = 1;
  localparam int EXC_INV  = 0;

endpackage

// File: rtl/D_Latch_Reg.sv
// Parameterised enabled data register with asynchronous active-high clear.
// Despite the name this is an edge-triggered flop; every data register of
// the adder is one of these.
module D_Latch_Reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d on enabled rising edges, clear asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fpa_seq_adder.sv
// Multi-cycle floating-point adder: IDLE -> ALIGN -> ADD -> NORM* -> DONE.
// Handshake: an operand pair transfers on a rising edge where in_valid=1 and
// in_ready=1 (in_ready is high only in IDLE); a result transfers on a rising
// edge where out_valid=1 and out_ready=1 (out_valid is high only in DONE).
// While out_valid=1 and out_ready=0 the ans_* outputs are held unchanged.
// exp==0 is exact zero (no denormals); exp==all-ones is Inf (mant 0) or NaN.
module fpa_seq_adder
  import fpa_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] a_mant,
  input  logic [MAN_W-1:0] b_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ans_sign,
  output logic [EXP_W-1:0] ans_exp,
  output logic [MAN_W-1:0] ans_mant,
  output logic [EXC_W-1:0] ans_except,
  output logic [2:0]       dbg_state_o
);

  // Internal mantissa layout: {carry, hidden, fraction}.
  localparam int MW = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] ALIGN_MAX = EXP_W'(MAN_W + 1);

  fpa_state_e state_q, state_d;

  // Working registers: operands ordered by magnitude (gt >= ls).
  logic             gt_sign_q, gt_sign_d;
  logic             ls_sign_q, ls_sign_d;
  logic [EXP_W-1:0] gt_exp_q,  gt_exp_d;
  logic [EXP_W-1:0] ls_exp_q,  ls_exp_d;
  logic [MW-1:0]    gt_mant_q, gt_mant_d;
  logic [MW-1:0]    ls_mant_q, ls_mant_d;
  logic             gt_exp_en, gt_mant_en, ls_mant_en;

  // Result registers, loaded once on the way into DONE.
  logic             ans_sign_q, ans_sign_d;
  logic [EXP_W-1:0] ans_exp_q,  ans_exp_d;
  logic [MAN_W-1:0] ans_mant_q, ans_mant_d;
  logic [EXC_W-1:0] ans_exc_q,  ans_exc_d;
  logic             ans_en;

  logic             accept;
  logic             a_ge;
  logic [MW-1:0]    a_int_mant, b_int_mant;
  logic             a_nan, b_nan, a_inf, b_inf, is_invalid;
  logic [EXP_W-1:0] exp_diff;
  logic [EXP_W-1:0] exp_inc;
  logic [MW-1:0]    mant_sum;

  // Expand a stored fraction to the internal layout; exp==0 means zero.
  function automatic logic [MW-1:0] int_mant(input logic [EXP_W-1:0] e,
                                             input logic [MAN_W-1:0] f);
    return (e == '0) ? '0 : {1'b0, 1'b1, f};
  endfunction

  assign accept     = in_valid && (state_q == S_IDLE);
  // Magnitude order on {exp, mant}; a tie keeps a as the larger operand.
  assign a_ge       = {a_exp, a_mant} >= {b_exp, b_mant};
  assign a_int_mant = int_mant(a_exp, a_mant);
  assign b_int_mant = int_mant(b_exp, b_mant);
  assign a_nan      = (a_exp == EXP_ONES) && (a_mant != '0);
  assign b_nan      = (b_exp == EXP_ONES) && (b_mant != '0);
  assign a_inf      = (a_exp == EXP_ONES) && (a_mant == '0);
  assign b_inf      = (b_exp == EXP_ONES) && (b_mant == '0);
  assign is_invalid = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));

  assign gt_sign_d  = a_ge ? a_sign : b_sign;
  assign ls_sign_d  = a_ge ? b_sign : a_sign;
  assign ls_exp_d   = a_ge ? b_exp  : a_exp;

  assign exp_diff   = gt_exp_q - ls_exp_q;
  assign exp_inc    = gt_exp_q + EXP_ONE;
  // gt >= ls in magnitude, so the subtraction never wraps.
  assign mant_sum   = (gt_sign_q == ls_sign_q) ? (gt_mant_q + ls_mant_q)
                                               : (gt_mant_q - ls_mant_q);

  // Next-state and register-load decisions for every FSM state.
  always_comb begin
    state_d    = state_q;
    gt_exp_en  = 1'b0;
    gt_exp_d   = gt_exp_q;
    gt_mant_en = 1'b0;
    gt_mant_d  = gt_mant_q;
    ls_mant_en = 1'b0;
    ls_mant_d  = ls_mant_q;
    ans_en     = 1'b0;
    ans_sign_d = 1'b0;
    ans_exp_d  = '0;
    ans_mant_d = '0;
    ans_exc_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          gt_exp_en  = 1'b1;
          gt_exp_d   = a_ge ? a_exp : b_exp;
          gt_mant_en = 1'b1;
          gt_mant_d  = a_ge ? a_int_mant : b_int_mant;
          ls_mant_en = 1'b1;
          ls_mant_d  = a_ge ? b_int_mant : a_int_mant;
          if (is_invalid) begin
            // Canonical NaN: +, exp all-ones, mant all-ones.
            ans_en               = 1'b1;
            ans_exp_d            = EXP_ONES;
            ans_mant_d           = '1;
            ans_exc_d[EXC_INV]   = 1'b1;
            state_d              = S_DONE;
          end else if (a_inf || b_inf) begin
            // One Inf (or two of the same sign) passes straight through.
            ans_en     = 1'b1;
            ans_sign_d = a_inf ? a_sign : b_sign;
            ans_exp_d  = EXP_ONES;
            state_d    = S_DONE;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        ls_mant_en = 1'b1;
        ls_mant_d  = (exp_diff > ALIGN_MAX) ? '0 : (ls_mant_q >> exp_diff);
        state_d    = S_ADD;
      end
      S_ADD: begin
        if (mant_sum == '0) begin
          // Exact cancellation always yields +0.
          ans_en              = 1'b1;
          ans_exc_d[EXC_ZERO] = 1'b1;
          state_d             = S_DONE;
        end else begin
          gt_mant_en = 1'b1;
          gt_mant_d  = mant_sum;
          state_d    = S_NORM;
        end
      end
      S_NORM: begin
        if (gt_mant_q[MW-1]) begin
          // Carry out: one right shift, exponent up; may overflow to Inf.
          ans_en     = 1'b1;
          ans_sign_d = gt_sign_q;
          state_d    = S_DONE;
          if (exp_inc == EXP_ONES) begin
            ans_exp_d          = EXP_ONES;
            ans_exc_d[EXC_OVF] = 1'b1;
          end else begin
            ans_exp_d  = exp_inc;
            ans_mant_d = gt_mant_q[MAN_W:1];
          end
        end else if (gt_mant_q[MAN_W]) begin
          // Hidden bit in place: already normalized.
          ans_en     = 1'b1;
          ans_sign_d = gt_sign_q;
          ans_exp_d  = gt_exp_q;
          ans_mant_d = gt_mant_q[MAN_W-1:0];
          state_d    = S_DONE;
        end else if (gt_exp_q == EXP_ONE) begin
          // Another left shift would need exp 0: flush to signed zero.
          ans_en             = 1'b1;
          ans_sign_d         = gt_sign_q;
          ans_exc_d[EXC_UNF] = 1'b1;
          state_d            = S_DONE;
        end else begin
          gt_mant_en = 1'b1;
          gt_mant_d  = gt_mant_q << 1;
          gt_exp_en  = 1'b1;
          gt_exp_d   = gt_exp_q - EXP_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register; clr aborts any operation in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  D_Latch_Reg #(.W(1)) u_gt_sign (
    .clk(clk), .clr(clr), .en(accept), .d(gt_sign_d), .q(gt_sign_q)
  );
  D_Latch_Reg #(.W(1)) u_ls_sign (
    .clk(clk), .clr(clr), .en(accept), .d(ls_sign_d), .q(ls_sign_q)
  );
  D_Latch_Reg #(.W(EXP_W)) u_gt_exp (
    .clk(clk), .clr(clr), .en(gt_exp_en), .d(gt_exp_d), .q(gt_exp_q)
  );
  D_Latch_Reg #(.W(EXP_W)) u_ls_exp (
    .clk(clk), .clr(clr), .en(accept), .d(ls_exp_d), .q(ls_exp_q)
  );
  D_Latch_Reg #(.W(MW)) u_gt_mant (
    .clk(clk), .clr(clr), .en(gt_mant_en), .d(gt_mant_d), .q(gt_mant_q)
  );
  D_Latch_Reg #(.W(MW)) u_ls_mant (
    .clk(clk), .clr(clr), .en(ls_mant_en), .d(ls_mant_d), .q(ls_mant_q)
  );
  D_Latch_Reg #(.W(1)) u_ans_sign (
    .clk(clk), .clr(clr), .en(ans_en), .d(ans_sign_d), .q(ans_sign_q)
  );
  D_Latch_Reg #(.W(EXP_W)) u_ans_exp (
    .clk(clk), .clr(clr), .en(ans_en), .d(ans_exp_d), .q(ans_exp_q)
  );
  D_Latch_Reg #(.W(MAN_W)) u_ans_mant (
    .clk(clk), .clr(clr), .en(ans_en), .d(ans_mant_d), .q(ans_mant_q)
  );
  D_Latch_Reg #(.W(EXC_W)) u_ans_exc (
    .clk(clk), .clr(clr), .en(ans_en), .d(ans_exc_d), .q(ans_exc_q)
  );

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign ans_sign    = ans_sign_q;
  assign ans_exp     = ans_exp_q;
  assign ans_mant    = ans_mant_q;
  assign ans_except  = ans_exc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpa_seq_adder.sv
// Bench for fpa_seq_adder (EXP_W=4, MAN_W=3, bias 7). Results are packed as
// {sign, exp[3:0], mant[2:0], except[3:0]}.
module tb_fpa_seq_adder;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid, in_ready;
  logic       a_sign, b_sign;
  logic [3:0] a_exp, b_exp;
  logic [2:0] a_mant, b_mant;
  logic       out_valid, out_ready;
  logic       ans_sign;
  logic [3:0] ans_exp;
  logic [2:0] ans_mant;
  logic [3:0] ans_except;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  fpa_seq_adder #(.EXP_W(4), .MAN_W(3)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_mant(a_mant), .b_mant(b_mant), .out_valid(out_valid),
    .out_ready(out_ready), .ans_sign(ans_sign), .ans_exp(ans_exp),
    .ans_mant(ans_mant), .ans_except(ans_except), .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: value semantics of the adder with truncating alignment.
  // lat = edges from accept (inclusive) until out_valid is seen.
  function automatic void model(input logic as_, input logic [3:0] ae, input logic [2:0] am,
                                input logic bs_, input logic [3:0] be, input logic [2:0] bm,
                                output logic [11:0] res, output int lat);
    bit a_nan, b_nan, a_inf, b_inf;
    int mg, ml, eg, el, sg, sl, s, msb, k, e;
    a_nan = (ae == 15) && (am != 0);
    b_nan = (be == 15) && (bm != 0);
    a_inf = (ae == 15) && (am == 0);
    b_inf = (be == 15) && (bm == 0);
    if (a_nan || b_nan || (a_inf && b_inf && as_ != bs_)) begin
      res = 12'b0_1111_111_0001; lat = 1; return;
    end
    if (a_inf) begin res = {as_, 4'hf, 3'b000, 4'b0000}; lat = 1; return; end
    if (b_inf) begin res = {bs_, 4'hf, 3'b000, 4'b0000}; lat = 1; return; end
    if (int'(ae) * 8 + int'(am) >= int'(be) * 8 + int'(bm)) begin
      eg = ae; el = be; sg = as_; sl = bs_;
      mg = (ae == 0) ? 0 : 8 + am;
      ml = (be == 0) ? 0 : 8 + bm;
    end else begin
      eg = be; el = ae; sg = bs_; sl = as_;
      mg = (be == 0) ? 0 : 8 + bm;
      ml = (ae == 0) ? 0 : 8 + am;
    end
    ml = (eg - el > 4) ? 0 : (ml >> (eg - el));
    s = (sg == sl) ? mg + ml : mg - ml;
    if (s == 0) begin res = 12'b0_0000_000_1000; lat = 3; return; end
    msb = 0;
    for (int i = 0; i < 5; i++) if (s[i]) msb = i;
    if (msb == 4) begin
      e = eg + 1;
      lat = 4;
      if (e == 15) res = {1'(sg), 4'hf, 3'b000, 4'b0100};
      else         res = {1'(sg), 4'(e), 3'((s >> 1) & 7), 4'b0000};
    end else if (msb == 3) begin
      lat = 4;
      res = {1'(sg), 4'(eg), 3'(s & 7), 4'b0000};
    end else begin
      k = 3 - msb;
      if (k >= eg) begin
        lat = 3 + eg;
        res = {1'(sg), 4'h0, 3'b000, 4'b0010};
      end else begin
        lat = 3 + k + 1;
        res = {1'(sg), 4'(eg - k), 3'((s << k) & 7), 4'b0000};
      end
    end
  endfunction

  // Scoreboard: every cycle with out_valid the outputs must equal the head.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_without_op", 32'(out_valid), 32'd0);
        end else begin
          check("result", 32'({ans_sign, ans_exp, ans_mant, ans_except}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver: one full transaction with optional result back-pressure.
  task automatic do_op(input logic as_, input logic [3:0] ae, input logic [2:0] am,
                       input logic bs_, input logic [3:0] be, input logic [2:0] bm,
                       input int stall);
    logic [11:0] r;
    int lat, cyc;
    model(as_, ae, am, bs_, be, bm, r, lat);
    exp_q.push_back(r);
    @(posedge clk); #1;
    a_sign = as_; a_exp = ae; a_mant = am;
    b_sign = bs_; b_exp = be; b_mant = bm;
    in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      in_valid = 1'($urandom_range(0, 1));
      a_sign = 1'($urandom_range(0, 1)); a_exp = 4'($urandom_range(0, 15));
      a_mant = 3'($urandom_range(0, 7));
      b_sign = 1'($urandom_range(0, 1)); b_exp = 4'($urandom_range(0, 15));
      b_mant = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL latency_timeout: got no out_valid in %0d cycles want %0d", cyc, lat);
      exp_q.delete();
      return;
    end
    check("latency", 32'(cyc), 32'(lat));
    repeat (stall) begin
      check("stall_busy", 32'({in_ready, out_valid}), 32'b01);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_to_idle", 32'({in_ready, out_valid}), 32'b10);
  endtask

  // Pin the model with a hand-computed result, then run it through the DUT.
  task automatic pinned(input string name, input logic as_, input logic [3:0] ae,
                        input logic [2:0] am, input logic bs_, input logic [3:0] be,
                        input logic [2:0] bm, input logic [11:0] want, input int want_lat,
                        input int stall);
    logic [11:0] r;
    int lat;
    model(as_, ae, am, bs_, be, bm, r, lat);
    check({name, "_model"}, 32'(r), 32'(want));
    check({name, "_model_lat"}, 32'(lat), 32'(want_lat));
    do_op(as_, ae, am, bs_, be, bm, stall);
  endtask

  initial begin
    logic       rs, rs2;
    logic [3:0] re, re2;
    logic [2:0] rm, rm2;
    // Reset
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_sign = 1'b0; a_exp = '0; a_mant = '0;
    b_sign = 1'b0; b_exp = '0; b_mant = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({in_ready, out_valid, ans_sign, ans_exp, ans_mant, ans_except}),
          32'({1'b1, 13'd0}));
    @(posedge clk); #1;
    clr = 1'b0;

    // Directed cases; the first also holds the result for 3 cycles.
    pinned("add_1p5_1p5", 1'b0, 4'd7, 3'b100, 1'b0, 4'd7, 3'b100, 12'b0_1000_100_0000, 4, 3);
    pinned("add_1_0p25",  1'b0, 4'd7, 3'b000, 1'b0, 4'd5, 3'b000, 12'b0_0111_010_0000, 4, 0);
    pinned("sub_1_1",     1'b0, 4'd7, 3'b000, 1'b1, 4'd7, 3'b000, 12'b0_0000_000_1000, 3, 1);
    pinned("overflow",    1'b0, 4'd14, 3'b111, 1'b0, 4'd14, 3'b111, 12'b0_1111_000_0100, 4, 0);
    pinned("underflow",   1'b0, 4'd1, 3'b001, 1'b1, 4'd1, 3'b000, 12'b0_0000_000_0010, 4, 2);
    pinned("inf_minus_inf", 1'b0, 4'd15, 3'b000, 1'b1, 4'd15, 3'b000, 12'b0_1111_111_0001, 1, 0);
    pinned("single_inf",  1'b1, 4'd3, 3'b101, 1'b1, 4'd15, 3'b000, 12'b1_1111_000_0000, 1, 0);
    pinned("deep_norm",   1'b0, 4'd8, 3'b001, 1'b1, 4'd8, 3'b000, 12'b0_0101_000_0000, 7, 0);

    // Abort during NORM: clr must cancel the result entirely.
    @(posedge clk); #1;
    a_sign = 1'b0; a_exp = 4'd8; a_mant = 3'b001;
    b_sign = 1'b1; b_exp = 4'd8; b_mant = 3'b000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_before_abort", 32'({in_ready, out_valid}), 32'b00);
    clr = 1'b1;
    #1;
    check("abort_outputs_zero", 32'({in_ready, out_valid, ans_sign, ans_exp, ans_mant, ans_except}),
          32'({1'b1, 13'd0}));
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_result_after_abort", 32'({out_valid, ans_sign, ans_exp, ans_mant, ans_except}), 32'd0);
    end
    pinned("after_abort", 1'b0, 4'd7, 3'b100, 1'b0, 4'd7, 3'b100, 12'b0_1000_100_0000, 4, 0);

    // Randomized operands, biased toward equal exponents for cancellations.
    for (int n = 0; n < 60; n++) begin
      rs  = 1'($urandom_range(0, 1));
      re  = 4'($urandom_range(0, 15));
      rm  = 3'($urandom_range(0, 7));
      rs2 = 1'($urandom_range(0, 1));
      rm2 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       re2 = 4'($urandom_range(0, 15));
        1:       re2 = (re > 0) ? re - 4'd1 : re;
        default: re2 = re;
      endcase
      do_op(rs, re, rm, rs2, re2, rm2, int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
